matmul_row_engine: RTL and testbench

MATMUL_ROW_ENGINE -- requirements
Module: matmul_row_engine

---
 rtl/matmul_row_engine_if.sv | 26 ++
 rtl/matmul_row_engine.sv | 91 +++++++++
 tb/tb_matmul_row_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_row_engine_if.sv
// Handshake and row-storage bus between the row-by-row matmul engine and its A/B/OUT memories.
// The engine side is the master; the storage/control environment is the slave.
interface matmul_row_engine_if #(
    parameter int MUL_SIZE  = 8,
    parameter int ADDR_BITS = $clog2(MUL_SIZE)
);
    logic                    start_mul;
    logic                    mul_done;
    logic [ADDR_BITS-1:0]    a_addr;
    logic [8*MUL_SIZE-1:0]   a_data;
    logic [ADDR_BITS-1:0]    b_addr;
    logic [8*MUL_SIZE-1:0]   b_data;
    logic [ADDR_BITS-1:0]    out_addr;
    logic [8*MUL_SIZE-1:0]   out_data;
    logic                    out_we;

    modport master (
        input  start_mul, a_data, b_data,
        output mul_done, a_addr, b_addr, out_addr, out_data, out_we
    );

    modport slave (
        output start_mul, a_data, b_data,
        input  mul_done, a_addr, b_addr, out_addr, out_data, out_we
    );
endinterface

// File: rtl/matmul_row_engine.sv
// N x N unsigned 8-bit matrix multiply, one output row per N+1 cycles, mod-256 lanes.
// state | meaning
// IDLE  | waiting for start_mul
// CALC  | accumulating A[i][k] * B[k][*] into the lanes, k = 0..N-1
// WRITE | presenting row i on the output port with out_we high
// DONE  | one-cycle mul_done pulse
module matmul_row_engine #(
    parameter int MUL_SIZE  = 8,
    parameter int ADDR_BITS = $clog2(MUL_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    matmul_row_engine_if.master bus
);
    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(MUL_SIZE - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_BITS-1:0]    i;
    logic [ADDR_BITS-1:0]    k;
    logic [8*MUL_SIZE-1:0]   acc;
    logic [8*MUL_SIZE-1:0]   acc_sum;
    logic [7:0]              a_elem;
    logic [15:0]             prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_mul) state_next = CALC;
            CALC:    if (k == LAST) state_next = WRITE;
            WRITE:   state_next = (i == LAST) ? DONE : CALC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-lane product is truncated to 8 bits before the add; carries never propagate.
    always_comb begin
        acc_sum = acc;
        prod    = '0;
        a_elem  = bus.a_data[8*int'(k) +: 8];
        for (int j = 0; j < MUL_SIZE; j++) begin
            prod = {8'b0, a_elem} * {8'b0, bus.b_data[8*j +: 8]};
            acc_sum[8*j +: 8] = acc[8*j +: 8] + prod[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i   <= '0;
            k   <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_mul) begin
                        i   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    k   <= (k == LAST) ? '0 : k + ADDR_BITS'(1);
                end
                WRITE: begin
                    acc <= '0;
                    if (i != LAST) i <= i + ADDR_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.a_addr   = (state == CALC)  ? i : '0;
    assign bus.b_addr   = (state == CALC)  ? k : '0;
    assign bus.out_addr = (state == WRITE) ? i : '0;
    assign bus.out_data = acc;
    assign bus.out_we   = (state == WRITE);
    assign bus.mul_done = (state == DONE);
endmodule

// File: tb/tb_matmul_row_engine.sv
// Directed/randomized bench for matmul_row_engine against a plain-arithmetic mod-256 matrix product.
module tb_matmul_row_engine;
    localparam int N  = 8;
    localparam int AB = 3;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk;
    logic rst_n;

    matmul_row_engine_if #(.MUL_SIZE(N), .ADDR_BITS(AB)) bus ();

    matmul_row_engine #(.MUL_SIZE(N), .ADDR_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  mat_a [N][N];
    logic [7:0]  mat_b [N][N];
    logic [63:0] ref_row [N];

    wr_t  wr_q[$];
    int   done_q[$];
    int   cyc;
    int   both_cnt;
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.a_data = '0;
        bus.b_data = '0;
        for (int j = 0; j < N; j++) begin
            bus.a_data[8*j +: 8] = mat_a[bus.a_addr][j];
            bus.b_data[8*j +: 8] = mat_b[bus.b_addr][j];
        end
    end

    // Output storage / event recorder: cyc holds the number of edges seen before this one.
    initial cyc = 0;
    initial both_cnt = 0;
    always @(posedge clk) begin
        if (bus.out_we) wr_q.push_back('{cyc: cyc, addr: bus.out_addr, data: bus.out_data});
        if (bus.mul_done) done_q.push_back(cyc);
        if (bus.out_we && bus.mul_done) both_cnt = both_cnt + 1;
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compute_ref();
        for (int r = 0; r < N; r++) begin
            ref_row[r] = '0;
            for (int c = 0; c < N; c++) begin
                int sum;
                sum = 0;
                for (int kk = 0; kk < N; kk++) sum += int'(mat_a[r][kk]) * int'(mat_b[kk][c]);
                ref_row[r][8*c +: 8] = 8'(sum % 256);
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat_a[r][c] = av;
                mat_b[r][c] = bv;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat_a[r][c] = 8'($urandom_range(0, 255));
                mat_b[r][c] = 8'($urandom_range(0, 255));
            end
    endtask

    // One full multiplication; optionally fires stray start pulses at cycle 10 and in the DONE cycle.
    task automatic run_mul(input string tag, input bit extra_starts);
        int  bw, bd, s;
        bit  got;
        compute_ref();
        bw = wr_q.size();
        bd = done_q.size();
        @(negedge clk);
        bus.start_mul = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.start_mul = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (done_q.size() > bd) begin
                bus.start_mul = 1'b0;
                got = 1'b1;
                break;
            end
            bus.start_mul = extra_starts && ((cyc == s + 10) || bus.mul_done);
            @(negedge clk);
        end
        bus.start_mul = 1'b0;
        check({tag, "_completed"}, 64'(got), 64'd1);
        if (extra_starts) repeat (100) @(negedge clk);
        else repeat (3) @(negedge clk);
        check({tag, "_write_count"}, 64'(wr_q.size() - bw), 64'd8);
        check({tag, "_done_count"}, 64'(done_q.size() - bd), 64'd1);
        if (got) check({tag, "_done_cycle"}, 64'(done_q[bd] - s), 64'd73);
        for (int r = 0; r < N; r++) begin
            if (bw + r < wr_q.size()) begin
                check($sformatf("%s_row%0d_addr", tag, r), 64'(wr_q[bw+r].addr), 64'(r));
                check($sformatf("%s_row%0d_data", tag, r), wr_q[bw+r].data, ref_row[r]);
                check($sformatf("%s_row%0d_cycle", tag, r), 64'(wr_q[bw+r].cyc - s), 64'(9*(r+1)));
            end
        end
    endtask

    initial begin
        int s, bw, bd;
        vectors     = 0;
        miscompares = 0;
        bus.start_mul = 1'b0;
        fill_const(8'h00, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_out_we",   64'(bus.out_we),   64'd0);
        check("reset_mul_done", 64'(bus.mul_done), 64'd0);
        check("reset_a_addr",   64'(bus.a_addr),   64'd0);
        check("reset_b_addr",   64'(bus.b_addr),   64'd0);
        check("reset_out_addr", 64'(bus.out_addr), 64'd0);
        check("reset_out_data", bus.out_data,      64'd0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat_a[r][c] = 8'(r*N + c);
                mat_b[r][c] = (r == c) ? 8'd1 : 8'd0;
            end
        run_mul("identity", 1'b0);

        fill_const(8'h02, 8'h03);
        run_mul("const23", 1'b0);
        check("const23_value", ref_row[5], 64'h3030303030303030);

        fill_const(8'hFF, 8'hFF);
        run_mul("overflow", 1'b0);
        check("overflow_value", ref_row[2], 64'h0808080808080808);

        fill_random();
        run_mul("stray_start", 1'b1);

        // Reset in the middle of a run, during a CALC cycle.
        fill_random();
        compute_ref();
        bw = wr_q.size();
        bd = done_q.size();
        @(negedge clk);
        bus.start_mul = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.start_mul = 1'b0;
        for (int t = 0; t < 40 && cyc < s + 20; t++) @(negedge clk);
        check("midrun_a_addr_busy", 64'(bus.a_addr), 64'd2);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_we",   64'(bus.out_we),   64'd0);
        check("midrun_rst_mul_done", 64'(bus.mul_done), 64'd0);
        check("midrun_rst_a_addr",   64'(bus.a_addr),   64'd0);
        check("midrun_rst_out_data", bus.out_data,      64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrun_writes_before_rst", 64'(wr_q.size() - bw), 64'd2);
        check("midrun_no_done", 64'(done_q.size() - bd), 64'd0);
        if (wr_q.size() - bw == 2)
            check("midrun_row1_data", wr_q[bw+1].data, ref_row[1]);
        run_mul("after_reset", 1'b0);

        fill_random();
        run_mul("random_a", 1'b0);
        fill_random();
        run_mul("random_b", 1'b0);

        check("we_done_exclusive", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
